// File: rtl/unified_buffer_arbiter.sv
// Unified buffer arbiter: sole owner of the UB SRAM port, running fixed-length
// bursts for compute reads, host write DMA and accumulator writeback.
module unified_buffer_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int MUL_SIZE   = 32,
  parameter int LEN_W      = 6,
  parameter int STARVE_MAX = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cr_req_i,
  input  logic [ADDR_W-1:0]   cr_addr_i,
  input  logic [LEN_W-1:0]    cr_len_i,
  output logic                cr_gnt_o,
  input  logic                hw_req_i,
  input  logic [ADDR_W-1:0]   hw_addr_i,
  input  logic [LEN_W-1:0]    hw_len_i,
  output logic                hw_gnt_o,
  input  logic                aw_req_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [LEN_W-1:0]    aw_len_i,
  output logic                aw_gnt_o,
  input  logic [DATA_W-1:0]   hw_wr_data_i,
  input  logic [DATA_W-1:0]   aw_wr_data_i,
  input  logic [MUL_SIZE-1:0] aw_wr_mask_i,
  output logic                hw_beat_o,
  output logic                aw_beat_o,
  output logic                cr_rd_valid_o,
  output logic [DATA_W-1:0]   cr_rd_data_o,
  output logic                cr_done_o,
  output logic                ub_en_o,
  output logic                ub_we_o,
  output logic [ADDR_W-1:0]   ub_addr_o,
  output logic [DATA_W-1:0]   ub_wr_data_o,
  output logic [MUL_SIZE-1:0] ub_wr_mask_o,
  input  logic [DATA_W-1:0]   ub_rd_data_i,
  output logic                busy_o,
  output logic [1:0]          owner_o
);
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CR = 2'd1, OWN_HW = 2'd2, OWN_AW = 2'd3} owner_t;

  state_t            r_state, w_nextState;
  owner_t            r_owner, w_winner;
  logic [ADDR_W-1:0] r_base, w_winAddr;
  logic [LEN_W-1:0]  r_len, r_k, w_winLen;
  logic [WAIT_W-1:0] r_hwWait, r_awWait;
  logic              r_rrAw, r_rdValid, r_crDone;
  logic              w_hwStarve, w_awStarve, w_grant, w_lastBeat, w_readBeat;

  assign w_hwStarve = hw_req_i && (r_hwWait == WAIT_MAX);
  assign w_awStarve = aw_req_i && (r_awWait == WAIT_MAX);
  assign w_grant    = (r_state == ST_IDLE) && (w_winner != OWN_NONE);
  assign w_lastBeat = (r_state == ST_BURST) && (r_k == r_len);
  assign w_readBeat = (r_state == ST_BURST) && (r_owner == OWN_CR);

  // Starving low-priority requesters outrank compute; rr breaks host/accumulator ties.
  always_comb begin
    w_winner = OWN_NONE;
    if (w_hwStarve && w_awStarve)  w_winner = r_rrAw ? OWN_AW : OWN_HW;
    else if (w_hwStarve)           w_winner = OWN_HW;
    else if (w_awStarve)           w_winner = OWN_AW;
    else if (cr_req_i)             w_winner = OWN_CR;
    else if (hw_req_i && aw_req_i) w_winner = r_rrAw ? OWN_AW : OWN_HW;
    else if (hw_req_i)             w_winner = OWN_HW;
    else if (aw_req_i)             w_winner = OWN_AW;
    case (w_winner)
      OWN_HW:  begin w_winAddr = hw_addr_i; w_winLen = hw_len_i; end
      OWN_AW:  begin w_winAddr = aw_addr_i; w_winLen = aw_len_i; end
      default: begin w_winAddr = cr_addr_i; w_winLen = cr_len_i; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_winner != OWN_NONE) w_nextState = ST_BURST;
      ST_BURST: if (r_k == r_len) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_owner <= OWN_NONE;
      r_base  <= '0;
      r_len   <= '0;
      r_k     <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      r_base  <= w_winAddr;
      r_len   <= w_winLen;
      r_k     <= '0;
    end else if (w_lastBeat) begin
      r_owner <= OWN_NONE;
    end else if (r_state == ST_BURST) begin
      r_k <= r_k + 1'b1;
    end
  end

  // Wait counters only age while a request is pending and someone else holds the port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hwWait <= '0;
      r_awWait <= '0;
      r_rrAw   <= 1'b0;
    end else begin
      if ((w_grant && w_winner == OWN_HW) || !hw_req_i) r_hwWait <= '0;
      else if (r_owner != OWN_HW && r_hwWait != WAIT_MAX) r_hwWait <= r_hwWait + 1'b1;
      if ((w_grant && w_winner == OWN_AW) || !aw_req_i) r_awWait <= '0;
      else if (r_owner != OWN_AW && r_awWait != WAIT_MAX) r_awWait <= r_awWait + 1'b1;
      if (w_grant && (w_winner == OWN_HW || w_winner == OWN_AW))
        r_rrAw <= (w_winner == OWN_HW);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdValid <= 1'b0;
      r_crDone  <= 1'b0;
    end else begin
      r_rdValid <= w_readBeat;
      r_crDone  <= w_readBeat && (r_k == r_len);
    end
  end

  always_comb begin
    ub_en_o      = 1'b0;
    ub_we_o      = 1'b0;
    ub_addr_o    = '0;
    ub_wr_data_o = '0;
    ub_wr_mask_o = '0;
    cr_gnt_o     = 1'b0;
    hw_gnt_o     = 1'b0;
    aw_gnt_o     = 1'b0;
    hw_beat_o    = 1'b0;
    aw_beat_o    = 1'b0;
    if (r_state == ST_BURST) begin
      ub_en_o   = 1'b1;
      ub_addr_o = r_base + {{(ADDR_W-LEN_W){1'b0}}, r_k};
      case (r_owner)
        OWN_CR: cr_gnt_o = (r_k == '0);
        OWN_HW: begin
          ub_we_o      = 1'b1;
          ub_wr_data_o = hw_wr_data_i;
          ub_wr_mask_o = '1;
          hw_beat_o    = 1'b1;
          hw_gnt_o     = (r_k == '0);
        end
        OWN_AW: begin
          ub_we_o      = 1'b1;
          ub_wr_data_o = aw_wr_data_i;
          ub_wr_mask_o = aw_wr_mask_i;
          aw_beat_o    = 1'b1;
          aw_gnt_o     = (r_k == '0);
        end
        default: ;
      endcase
    end
  end

  assign cr_rd_valid_o = r_rdValid;
  assign cr_done_o     = r_crDone;
  assign cr_rd_data_o  = ub_rd_data_i;
  assign busy_o        = (r_state == ST_BURST);
  assign owner_o       = r_owner;

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// Bench for unified_buffer_arbiter: directed scenarios plus random traffic,
// checked every cycle against a burst-queue reference model.
module tb_unified_buffer_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 256;
  localparam int MUL_SIZE   = 32;
  localparam int LEN_W      = 6;
  localparam int STARVE_MAX = 16;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                cr_req_i = 1'b0, hw_req_i = 1'b0, aw_req_i = 1'b0;
  logic [ADDR_W-1:0]   cr_addr_i = '0, hw_addr_i = '0, aw_addr_i = '0;
  logic [LEN_W-1:0]    cr_len_i = '0, hw_len_i = '0, aw_len_i = '0;
  logic [DATA_W-1:0]   hw_wr_data_i = '0, aw_wr_data_i = '0, ub_rd_data_i = '0;
  logic [MUL_SIZE-1:0] aw_wr_mask_i = '0;
  logic                cr_gnt_o, hw_gnt_o, aw_gnt_o, hw_beat_o, aw_beat_o;
  logic                cr_rd_valid_o, cr_done_o, ub_en_o, ub_we_o, busy_o;
  logic [DATA_W-1:0]   cr_rd_data_o, ub_wr_data_o;
  logic [ADDR_W-1:0]   ub_addr_o;
  logic [MUL_SIZE-1:0] ub_wr_mask_o;
  logic [1:0]          owner_o;

  always #5 clk_i = ~clk_i;

  unified_buffer_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MUL_SIZE(MUL_SIZE), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cr_req_i(cr_req_i), .cr_addr_i(cr_addr_i), .cr_len_i(cr_len_i), .cr_gnt_o(cr_gnt_o),
    .hw_req_i(hw_req_i), .hw_addr_i(hw_addr_i), .hw_len_i(hw_len_i), .hw_gnt_o(hw_gnt_o),
    .aw_req_i(aw_req_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_gnt_o(aw_gnt_o),
    .hw_wr_data_i(hw_wr_data_i), .aw_wr_data_i(aw_wr_data_i), .aw_wr_mask_i(aw_wr_mask_i),
    .hw_beat_o(hw_beat_o), .aw_beat_o(aw_beat_o),
    .cr_rd_valid_o(cr_rd_valid_o), .cr_rd_data_o(cr_rd_data_o), .cr_done_o(cr_done_o),
    .ub_en_o(ub_en_o), .ub_we_o(ub_we_o), .ub_addr_o(ub_addr_o),
    .ub_wr_data_o(ub_wr_data_o), .ub_wr_mask_o(ub_wr_mask_o), .ub_rd_data_i(ub_rd_data_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  // One record per expected UB cycle; owner 0 marks an idle cycle.
  typedef struct {
    int owner;
    int addr;
    bit gnt;
    bit last;
  } beat_t;

  beat_t    beatQ[$];
  beat_t    cur;
  int       waitHw, waitAw;
  bit       hostFirst, expValid, expDone;
  bit       crHold, hwHold, awHold, randomMode, fixedMask;
  bit [3:0] justGranted;
  int       errors = 0;
  int       checks = 0;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] randData();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LEN_W-1:0] randLen();
    if ($urandom_range(0, 7) == 0) return LEN_W'($urandom_range(0, 63));
    return LEN_W'($urandom_range(0, 3));
  endfunction

  task automatic modelReset();
    beatQ.delete();
    cur         = '{0, 0, 1'b0, 1'b0};
    waitHw      = 0;
    waitAw      = 0;
    hostFirst   = 1'b1;
    expValid    = 1'b0;
    expDone     = 1'b0;
    justGranted = '0;
  endtask

  // Advance the reference model across one rising edge using the pre-edge inputs.
  task automatic modelEdge();
    beat_t prev     = cur;
    int    win      = 0;
    int    base     = 0;
    int    len      = 0;
    bit    hwStarve = hw_req_i && (waitHw == STARVE_MAX);
    bit    awStarve = aw_req_i && (waitAw == STARVE_MAX);
    if (prev.owner == 0) begin
      if (hwStarve && awStarve)      win = hostFirst ? 2 : 3;
      else if (hwStarve)             win = 2;
      else if (awStarve)             win = 3;
      else if (cr_req_i)             win = 1;
      else if (hw_req_i && aw_req_i) win = hostFirst ? 2 : 3;
      else if (hw_req_i)             win = 2;
      else if (aw_req_i)             win = 3;
    end
    if (win == 2 || !hw_req_i) waitHw = 0;
    else if (prev.owner != 2 && waitHw < STARVE_MAX) waitHw++;
    if (win == 3 || !aw_req_i) waitAw = 0;
    else if (prev.owner != 3 && waitAw < STARVE_MAX) waitAw++;
    case (win)
      1: begin base = int'(cr_addr_i); len = int'(cr_len_i); end
      2: begin base = int'(hw_addr_i); len = int'(hw_len_i); hostFirst = 1'b0; end
      3: begin base = int'(aw_addr_i); len = int'(aw_len_i); hostFirst = 1'b1; end
      default: ;
    endcase
    if (win != 0) begin
      justGranted[win] = 1'b1;
      for (int b = 0; b <= len; b++)
        beatQ.push_back('{win, (base + b) % (1 << ADDR_W), (b == 0), (b == len)});
    end
    expValid = (prev.owner == 1);
    expDone  = (prev.owner == 1) && prev.last;
    if (beatQ.size() > 0) cur = beatQ.pop_front();
    else                  cur = '{0, 0, 1'b0, 1'b0};
  endtask

  task automatic driveInputs();
    if (justGranted[1] && !crHold) cr_req_i = 1'b0;
    if (justGranted[2] && !hwHold) hw_req_i = 1'b0;
    if (justGranted[3] && !awHold) aw_req_i = 1'b0;
    justGranted = '0;
    if (randomMode) begin
      if (!cr_req_i && $urandom_range(0, 3) == 0) begin
        cr_req_i = 1'b1; cr_addr_i = ADDR_W'($urandom); cr_len_i = randLen();
      end else if (cr_req_i && $urandom_range(0, 40) == 0) cr_req_i = 1'b0;
      if (!hw_req_i && $urandom_range(0, 3) == 0) begin
        hw_req_i = 1'b1; hw_addr_i = ADDR_W'($urandom); hw_len_i = randLen();
      end else if (hw_req_i && $urandom_range(0, 40) == 0) hw_req_i = 1'b0;
      if (!aw_req_i && $urandom_range(0, 3) == 0) begin
        aw_req_i = 1'b1; aw_addr_i = ADDR_W'($urandom); aw_len_i = randLen();
      end else if (aw_req_i && $urandom_range(0, 40) == 0) aw_req_i = 1'b0;
    end
    hw_wr_data_i = randData();
    aw_wr_data_i = randData();
    ub_rd_data_i = randData();
    aw_wr_mask_i = fixedMask ? 32'h8000_0000 : MUL_SIZE'($urandom);
  endtask

  task automatic checkCycle();
    bit en = (cur.owner != 0);
    bit we = (cur.owner >= 2);
    checkOutput("busy", 256'(busy_o), 256'(en));
    checkOutput("owner", 256'(owner_o), 256'(cur.owner));
    checkOutput("ub_en", 256'(ub_en_o), 256'(en));
    checkOutput("ub_we", 256'(ub_we_o), 256'(we));
    if (en) checkOutput("ub_addr", 256'(ub_addr_o), 256'(cur.addr));
    checkOutput("cr_gnt", 256'(cr_gnt_o), 256'(cur.gnt && cur.owner == 1));
    checkOutput("hw_gnt", 256'(hw_gnt_o), 256'(cur.gnt && cur.owner == 2));
    checkOutput("aw_gnt", 256'(aw_gnt_o), 256'(cur.gnt && cur.owner == 3));
    checkOutput("hw_beat", 256'(hw_beat_o), 256'(cur.owner == 2));
    checkOutput("aw_beat", 256'(aw_beat_o), 256'(cur.owner == 3));
    checkOutput("cr_rd_valid", 256'(cr_rd_valid_o), 256'(expValid));
    checkOutput("cr_done", 256'(cr_done_o), 256'(expDone));
    checkOutput("cr_rd_data", 256'(cr_rd_data_o), 256'(ub_rd_data_i));
    if (cur.owner == 2) begin
      checkOutput("ub_wr_data_hw", 256'(ub_wr_data_o), 256'(hw_wr_data_i));
      checkOutput("ub_wr_mask_hw", 256'(ub_wr_mask_o), 256'(32'hFFFF_FFFF));
    end
    if (cur.owner == 3) begin
      checkOutput("ub_wr_data_aw", 256'(ub_wr_data_o), 256'(aw_wr_data_i));
      checkOutput("ub_wr_mask_aw", 256'(ub_wr_mask_o), 256'(aw_wr_mask_i));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", 256'(busy_o), 256'(0));
    checkOutput("rst_owner", 256'(owner_o), 256'(0));
    checkOutput("rst_ub_en", 256'(ub_en_o), 256'(0));
    checkOutput("rst_ub_we", 256'(ub_we_o), 256'(0));
    checkOutput("rst_ub_addr", 256'(ub_addr_o), 256'(0));
    checkOutput("rst_ub_wr_data", 256'(ub_wr_data_o), 256'(0));
    checkOutput("rst_ub_wr_mask", 256'(ub_wr_mask_o), 256'(0));
    checkOutput("rst_gnts", 256'({cr_gnt_o, hw_gnt_o, aw_gnt_o}), 256'(0));
    checkOutput("rst_beats", 256'({hw_beat_o, aw_beat_o}), 256'(0));
    checkOutput("rst_rd_valid", 256'(cr_rd_valid_o), 256'(0));
    checkOutput("rst_done", 256'(cr_done_o), 256'(0));
    checkOutput("rst_rd_data", 256'(cr_rd_data_o), 256'(ub_rd_data_i));
  endtask

  // One clock: model crosses the edge, new inputs go out, then outputs are compared.
  task automatic applyStimulus();
    @(posedge clk_i);
    modelEdge();
    #1;
    driveInputs();
    #1;
    checkCycle();
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges, released mid-cycle.
  task automatic doReset();
    #1 rst_i = 1'b0;
    #1 checkResetState();
    cr_req_i = 1'b0;
    hw_req_i = 1'b0;
    aw_req_i = 1'b0;
    crHold   = 1'b0;
    hwHold   = 1'b0;
    awHold   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
  endtask

  initial begin
    modelReset();
    {crHold, hwHold, awHold, randomMode, fixedMask} = '0;
    ub_rd_data_i = randData();
    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    checkResetState();
    rst_i = 1'b1;

    $display("[TB] single compute read");
    cr_req_i = 1'b1; cr_addr_i = 12'h010; cr_len_i = 6'd3;
    repeat (8) applyStimulus();

    $display("[TB] host write with address wrap");
    hw_req_i = 1'b1; hw_addr_i = 12'hFFE; hw_len_i = 6'd3;
    repeat (7) applyStimulus();

    $display("[TB] simultaneous requests then host/accumulator alternation");
    cr_req_i = 1'b1; cr_addr_i = 12'h100; cr_len_i = 6'd0;
    hw_req_i = 1'b1; hw_addr_i = 12'h200; hw_len_i = 6'd0;
    aw_req_i = 1'b1; aw_addr_i = 12'h300; aw_len_i = 6'd0;
    repeat (8) applyStimulus();
    hwHold = 1'b1; awHold = 1'b1;
    hw_req_i = 1'b1; aw_req_i = 1'b1;
    repeat (10) applyStimulus();
    hwHold = 1'b0; awHold = 1'b0;
    repeat (6) applyStimulus();

    $display("[TB] accumulator starvation against held compute reads");
    crHold = 1'b1;
    cr_req_i = 1'b1; cr_addr_i = 12'h040; cr_len_i = 6'd7;
    aw_req_i = 1'b1; aw_addr_i = 12'h0A0; aw_len_i = 6'd0;
    repeat (30) applyStimulus();
    crHold = 1'b0;
    repeat (12) applyStimulus();

    $display("[TB] accumulator single-lane mask");
    fixedMask = 1'b1;
    aw_req_i = 1'b1; aw_addr_i = 12'h055; aw_len_i = 6'd1;
    repeat (5) applyStimulus();
    fixedMask = 1'b0;

    $display("[TB] reset in the middle of a read burst");
    cr_req_i = 1'b1; cr_addr_i = 12'h300; cr_len_i = 6'd7;
    repeat (3) applyStimulus();
    doReset();
    cr_req_i = 1'b1; cr_addr_i = 12'h020; cr_len_i = 6'd1;
    repeat (6) applyStimulus();

    $display("[TB] random traffic");
    randomMode = 1'b1;
    repeat (1500) applyStimulus();
    doReset();
    repeat (1500) applyStimulus();
    randomMode = 1'b0;
    cr_req_i = 1'b0; hw_req_i = 1'b0; aw_req_i = 1'b0;
    repeat (70) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_buffer_arbiter.md
# unified_buffer_arbiter

Single owner of the unified buffer (UB) SRAM port. It arbitrates burst accesses from three requesters: the compute activation read path, host write DMA and accumulator writeback. It generates per-beat UB addresses and controls, routes write data and masks, and returns read data with a valid strobe. It sits between the compute control unit's UB read address stream and the single-port UB macro, and replaces direct UB wiring.

## Interface
- ADDR_W, 12, UB word address width
- DATA_W, 256, UB word width (MUL_SIZE lanes × 8 bit)
- MUL_SIZE, 32, lanes per word; width of the write mask
- LEN_W, 6, burst length field; encodes beats−1 (1..64 beats)
- STARVE_MAX, 16, wait cycles after which a low-priority requester outranks compute
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cr_req_i / hw_req_i / aw_req_i  in  1  burst request (compute read / host write / accumulator write)
- cr_addr_i / hw_addr_i / aw_addr_i  in  ADDR_W  burst start address, held until grant
- cr_len_i / hw_len_i / aw_len_i  in  LEN_W  beats−1, held until grant
- cr_gnt_o / hw_gnt_o / aw_gnt_o  out  1  one-cycle pulse in the first beat cycle of the granted burst
- hw_wr_data_i / aw_wr_data_i  in  DATA_W  write data for the current beat
- aw_wr_mask_i  in  MUL_SIZE  lane mask for accumulator writes; host writes use all-ones
- hw_beat_o / aw_beat_o  out  1  the current beat's data is consumed this cycle; requester advances on the next edge
- cr_rd_valid_o  out  1  cr_rd_data_o holds the data for one read beat
- cr_rd_data_o  out  DATA_W  read data; passthrough of ub_rd_data_i
- cr_done_o  out  1  pulse coincident with the last cr_rd_valid_o of a burst
- ub_en_o  out  1  UB access enable
- ub_we_o  out  1  UB write enable
- ub_addr_o  out  ADDR_W  UB address
- ub_wr_data_o  out  DATA_W  UB write data
- ub_wr_mask_o  out  MUL_SIZE  UB lane mask
- ub_rd_data_i  in  DATA_W  UB read data, 1-cycle latency
- busy_o  out  1  a burst is in progress
- owner_o  out  2  current owner: 0 none, 1 compute read, 2 host write, 3 accumulator write

## Operation
- FSM states: IDLE, BURST.
- IDLE with at least one request asserted:
  - Arbitrate at the edge and latch winner, address and length.
  - Enter BURST with beat counter k=0.
- IDLE with no request: remain IDLE.
- BURST, beat k (k=0..len):
  - ub_en_o=1; ub_addr_o = base + k, modulo 2^ADDR_W (wraps from 0xFFF to 0x000).
  - ub_we_o=1 for host or accumulator owner, else 0.
  - ub_wr_data_o and ub_wr_mask_o come combinationally from the owner.
  - Owner's *_beat_o=1.
- At k==len: return to IDLE. This leaves exactly one idle (arbitration) cycle between bursts.
- Priority at arbitration:
  - A starving requester wins first. Starving means its wait counter == STARVE_MAX.
  - Otherwise compute read wins.
  - Otherwise host and accumulator alternate via round-robin pointer rr. rr resets to favour host and flips to the other requester after each host or accumulator grant.
  - If both are starving, rr decides between them.
- Wait counters (host, accumulator):
  - Increment each cycle the request is high and that requester is not the owner; saturate at STARVE_MAX.
  - Clear on that requester's grant.
  - Clear when its request is low.
- No preemption: a burst always runs to len+1 beats.
- A request dropped before grant is never granted.
- The owner's request line is ignored during its own burst. If still high at the next IDLE, it is a new burst.
- Data/mask lines of non-owners are ignored.
- All non-owner grant and beat outputs are 0.
- Reset mid-burst: the burst is abandoned immediately. State goes to IDLE, counters and rr clear, and pending reads produce no valid. Requesters re-request.

## Timing
- Reset value of all outputs is 0, including ub_en_o, ub_we_o, all grants and beats, cr_rd_valid_o, cr_done_o, busy_o and owner_o. cr_rd_data_o follows ub_rd_data_i.
- Grant latency: request sampled in IDLE at edge E → gnt pulse and beat 0 in the cycle after E.
- busy_o and owner_o are valid for exactly len+1 cycles per burst.
- Read valid: cr_rd_valid_o is the registered copy of (ub_en_o & ~ub_we_o & owner==compute read), i.e. one cycle after each read beat.
- cr_done_o comes one cycle after the last read beat; it may overlap the following IDLE cycle or the next burst's first beat.
- Burst throughput: len+1 beats in len+2 cycles.
- State, counters, rr and owner are registered. The ub_* outputs are decoded from registered state, except write data and mask, which are combinational from the owner.

## Test plan
- **Single compute read:** cr_req with addr 0x010, len 3 → cr_gnt pulse 1 cycle later. ub_addr 0x010..0x013 on 4 consecutive cycles with ub_we=0. cr_rd_valid on the 4 following cycles. cr_done with the 4th valid.
- **Host write wrap:** hw_req with addr 0xFFE, len 3 → ub_addr 0xFFE, 0xFFF, 0x000, 0x001 with ub_we=1, mask all-ones, hw_beat high for 4 cycles. ub_wr_data equals hw_wr_data_i each beat.
- **Simultaneous requests:** all three requests in the same cycle, each len 0 → grant order compute, host, accumulator, one idle cycle apart. Then, with compute idle, host and accumulator held → grants alternate host/accumulator.
- **Starvation:** cr_req held continuously with len 7 while aw_req is held → after the aw wait counter reaches 16, the next arbitration grants aw ahead of compute.
- **Accumulator mask:** aw burst with aw_wr_mask_i = 0x8000_0000 → ub_wr_mask_o = 0x8000_0000 and ub_we=1 for that beat.
- **Reset mid-burst:** rst_i low at beat 2 of a len-7 read → all outputs 0 asynchronously, and no cr_rd_valid afterward. After release, a fresh cr_req is granted 1 cycle after sampling.
